// File: rtl/display_mux_bcd.sv
// display_mux_bcd: sequential double-dabble BCD converter driving a multiplexed common-anode seven-segment display
module display_mux_bcd #(
  parameter int WIDTH = 9,
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit SIGNED = 0,
  parameter bit LZB = 1
) (
  input logic clk,
  input logic rst,
  input logic [WIDTH-1:0] valor,
  input logic load,
  output logic busy,
  output logic [6:0] SSeg,
  output logic [DIGITS-1:0] an
);
  localparam int NBCD = (3 * WIDTH) / 10 + 1;
  localparam int BW = 4 * NBCD;
  localparam int ND = NBCD > DIGITS ? NBCD : DIGITS;
  localparam int EW = 4 * ND;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0] GL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0] bcd, adj, bcd_n;
  logic neg, ovf, last;
  logic [EW-1:0] disp;
  logic disp_neg, disp_ovf;
  logic [RW-1:0] rcnt;
  logic [IW-1:0] idx;
  logic [3:0] cur;
  logic [6:0] glyph;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == CONV;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (load ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  always_comb begin
    adj = '0;
    ovf = 1'b0;
    for (int i = 0; i < NBCD; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    bcd_n = BW'({adj, sh[WIDTH-1]});
    for (int i = 0; i < NBCD; i++)
      ovf = ovf | ((i >= DIGITS - int'(neg)) && bcd_n[4*i +: 4] != 4'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh <= '0;
      bcd <= '0;
      neg <= 1'b0;
      disp <= '0;
      disp_neg <= 1'b0;
      disp_ovf <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
      bcd <= '0;
      if (load) begin
        neg <= SIGNED && valor[WIDTH-1];
        sh <= (SIGNED && valor[WIDTH-1]) ? -valor : valor;
      end
    end else begin
      cnt <= cnt + CW'(1);
      sh <= sh << 1;
      bcd <= bcd_n;
      if (last) begin
        disp <= EW'(bcd_n);
        disp_neg <= neg;
        disp_ovf <= ovf;
      end
    end
  end
  always_comb begin
    cur = disp[{idx, 2'b00} +: 4];
    glyph = (disp_ovf || (disp_neg && idx == IW'(DIGITS - 1))) ? 7'h3F :
            (LZB && idx != '0 && (disp >> {idx, 2'b00}) == '0) ? 7'h7F : GL[cur];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx <= '0;
      SSeg <= 7'b1000000;
      an <= ~DIGITS'(1);
    end else begin
      rcnt <= rcnt == RW'(REFRESH_DIV - 1) ? '0 : rcnt + RW'(1);
      if (rcnt == RW'(REFRESH_DIV - 1))
        idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      SSeg <= glyph;
      an <= ~(DIGITS'(1) << idx);
    end
  end
endmodule

// File: doc/display_mux_bcd.md
# display_mux_bcd

Parametrised multiplexed seven-segment display driver: it converts a binary operand to BCD and scans the result across a common-anode display. The conversion is a sequential double-dabble, and the block supports optional signed (two's-complement) input, leading-zero blanking and overflow indication. It replaces the fixed 9-bit, always-positive display path between the switch/adder logic and the board's `SSeg`/`an` pins.

## Interface
- `WIDTH`, 9: operand width in bits (2..20).
- `DIGITS`, 4: number of physical digits (2..8).
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit (≥2).
- `SIGNED`, 0: 1 treats `valor` as two's complement.
- `LZB`, 1: 1 blanks leading zeros.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valor`  in  WIDTH  operand to display.
- `load`  in  1  one-cycle request to capture `valor` and start conversion.
- `busy`  out  1  conversion in progress; `load` is ignored while high.
- `SSeg`  out  7  segments, active-low; bit 0 = a … bit 6 = g.
- `an`  out  DIGITS  digit enables, active-low one-hot; `an[0]` is the rightmost digit.

## Operation
- **Conversion FSM states:** IDLE and CONV.
  - IDLE + `load` → capture the operand → CONV, `busy`=1.
  - CONV runs exactly WIDTH shift/add-3 iterations, then → IDLE, `busy`=0.
- **Capture:**
  - `SIGNED`=0: magnitude = `valor`, neg=0.
  - `SIGNED`=1 and MSB set: magnitude = −`valor` in WIDTH bits, neg=1. The most negative value is converted correctly (magnitude 2^(WIDTH−1)).
- **BCD register:** internal width is 4·NBCD, with NBCD = (3·WIDTH)/10 + 1, so 2^WIDTH−1 always fits.
- **Available digits:** AVAIL = DIGITS − neg.
- **Overflow:** any nonzero BCD digit at index ≥ AVAIL → every digit shows dash (g only, `SSeg`=7'b0111111).
- **Display register:** written only at conversion end. It holds digits, neg and overflow, and keeps its value until the next completed conversion.
- **Blanking:**
  - With `LZB`=1, digits above the most significant nonzero digit are blank (`SSeg`=7'h7F). Digit 0 is never blanked.
  - neg=1 → digit DIGITS−1 shows minus (g only). The minus is never blanked.
- **Glyphs:** standard 0–9. 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 5 = 7'b0010010.
- **Scan:**
  - A refresh counter runs 0..REFRESH_DIV−1 and wraps.
  - On wrap, the digit index increments mod DIGITS (0→1→…→DIGITS−1→0).
- **Outputs:** `SSeg` and `an` are registered from the index and the display register.
- **Concurrency:** scan never stalls for conversion. A display-register update is visible on the next output register cycle, mid-digit if necessary.

## Timing
- **Reset values:**
  - FSM=IDLE, `busy`=0.
  - Display register = value 0, neg=0, overflow=0.
  - Refresh counter = 0, index = 0.
  - `an` = all ones except `an[0]`=0.
  - `SSeg` = 7'b1000000.
- **Load:** `load` sampled at edge k (FSM IDLE) → `busy`=1 after edge k. The last iteration and display-register write occur at edge k+WIDTH; `busy`=0 after edge k+WIDTH.
- **Busy:** `busy` is high for exactly WIDTH cycles.
- **Back-to-back loads:** `load` at edge k+WIDTH is ignored (`busy` still high at sample). `load` at edge k+WIDTH+1 is accepted.
- **Output latency:** the display register written at edge t appears on `SSeg` after edge t+1.
- **Digit dwell:** index changes every REFRESH_DIV cycles; `an` follows one cycle later. A full frame is DIGITS·REFRESH_DIV cycles.
- **Reset priority:** `rst` asserted mid-conversion aborts it. The display register returns to 0 and the partial result is discarded. `rst` has priority over a simultaneous `load`.

## Test plan
- **Reset:** `rst` 2 cycles → `busy`=0, `an`=4'b1110, `SSeg`=7'b1000000. Scan advances `an` to 4'b1101 after REFRESH_DIV(=4)+1 cycles.
- **Unsigned 255 (WIDTH=9):** `load` with `valor`=255 → `busy` high 9 cycles, then the frame shows blank, 2, 5, 5 on digits 3..0. With `LZB`=0, digit 3 shows 0.
- **Signed −5 (SIGNED=1, WIDTH=9):** `valor`=9'h1FB → digit 3 minus, digits 2..1 blank, digit 0 = 5. Also `valor`=9'h100 (−256) → minus, 2, 5, 6.
- **Overflow (WIDTH=16, DIGITS=4):** `valor`=12345 → all four digits 7'b0111111. Signed −1000 → also all dashes (AVAIL=3).
- **Load during busy:** `valor`=7 loaded, then `load` with `valor`=9 at cycles 1 and WIDTH → both ignored, display shows 7. `load` at cycle WIDTH+1 → 9 after a further WIDTH cycles.
- **Reset mid-conversion:** `rst` at cycle 4 of converting 300 → `busy`=0 next cycle, display shows 0 on digit 0 with the other digits blank.
